// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

  // Width of the controller state encoding.
  localparam int STATE_W = 2;

  // Fill bit for the divide-by-zero quotient (quotient becomes all ones).
  localparam logic DIV0_Q_FILL = 1'b1;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left by one, then
// subtract the divisor from the partial remainder if it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  // The shifted partial remainder needs one extra bit: a divisor above
  // 2^(WIDTH-1) can leave a remainder whose doubled value overflows WIDTH bits.
  logic [WIDTH:0] partial;
  logic           fits;

  // Trial subtraction and quotient-bit selection.
  always_comb begin
    partial  = {rem, quo[WIDTH-1]};
    fits     = (partial >= {1'b0, divisor});
    rem_next = fits ? (partial[WIDTH-1:0] - divisor) : partial[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/div_iter.sv
// Multi-cycle restoring divider for the MIPS execute stage (DIV / DIVU).
// Quotient drives LO, remainder drives HI. Start/busy/done handshake with
// a cancel input for pipeline flushes.
// Optional build macro DIV_ITER_FAST_EN: a zero divisor or a divisor whose
// magnitude exceeds the dividend skips the iteration phase (done 2 edges
// after start); otherwise latency is always WIDTH+2 edges.
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] rem_reg, rem_next;
  logic [WIDTH-1:0] quo_reg, quo_next;
  logic [WIDTH-1:0] dvs_reg, dvs_next;
  logic [WIDTH-1:0] dvd_reg, dvd_next;
  logic             sign_q_reg, sign_q_next;
  logic             sign_r_reg, sign_r_next;
  logic             div0_reg, div0_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic [WIDTH-1:0] quot_out_reg, quot_out_next;
  logic [WIDTH-1:0] rem_out_reg, rem_out_next;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] step_rem, step_quo;

  // Operand magnitudes in WIDTH-bit arithmetic; |MIN| wraps to 2^(WIDTH-1),
  // which is exactly right when read back as unsigned.
  always_comb begin
    abs_a = (is_signed && dividend[WIDTH-1]) ? ('0 - dividend) : dividend;
    abs_b = (is_signed && divisor[WIDTH-1])  ? ('0 - divisor)  : divisor;
  end

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem      (rem_reg),
    .quo      (quo_reg),
    .divisor  (dvs_reg),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state, datapath and output decisions; cancel overrides everything.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    rem_next      = rem_reg;
    quo_next      = quo_reg;
    dvs_next      = dvs_reg;
    dvd_next      = dvd_reg;
    sign_q_next   = sign_q_reg;
    sign_r_next   = sign_r_reg;
    div0_next     = div0_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    quot_out_next = quot_out_reg;
    rem_out_next  = rem_out_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next  = CALC;
          cnt_next    = '0;
          rem_next    = '0;
          quo_next    = abs_a;
          dvs_next    = abs_b;
          dvd_next    = dividend;
          sign_q_next = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          sign_r_next = is_signed & dividend[WIDTH-1];
          div0_next   = (divisor == '0);
          busy_next   = 1'b1;
`ifdef DIV_ITER_FAST_EN
          // Trivial cases: preload the final quotient/remainder magnitudes.
          if ((divisor == '0) || (abs_b > abs_a)) begin
            state_next = FIX;
            rem_next   = abs_a;
            quo_next   = '0;
          end
`endif
        end
      end

      CALC: begin
        rem_next = step_rem;
        quo_next = step_quo;
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == LAST_STEP) state_next = FIX;
      end

      FIX: begin
        state_next = IDLE;
        cnt_next   = '0;
        busy_next  = 1'b0;
        done_next  = 1'b1;
        if (div0_reg) begin
          // Divide by zero: fixed pattern, dividend passed through untouched.
          quot_out_next = {WIDTH{DIV0_Q_FILL}};
          rem_out_next  = dvd_reg;
        end else begin
          quot_out_next = sign_q_reg ? ('0 - quo_reg) : quo_reg;
          rem_out_next  = sign_r_reg ? ('0 - rem_reg) : rem_reg;
        end
      end

      default: state_next = IDLE;
    endcase

    if (cancel) begin
      state_next    = IDLE;
      cnt_next      = '0;
      busy_next     = 1'b0;
      done_next     = 1'b0;
      quot_out_next = quot_out_reg;
      rem_out_next  = rem_out_reg;
    end
  end

  // Datapath, handshake and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg      <= '0;
      rem_reg      <= '0;
      quo_reg      <= '0;
      dvs_reg      <= '0;
      dvd_reg      <= '0;
      sign_q_reg   <= 1'b0;
      sign_r_reg   <= 1'b0;
      div0_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      quot_out_reg <= '0;
      rem_out_reg  <= '0;
    end else begin
      cnt_reg      <= cnt_next;
      rem_reg      <= rem_next;
      quo_reg      <= quo_next;
      dvs_reg      <= dvs_next;
      dvd_reg      <= dvd_next;
      sign_q_reg   <= sign_q_next;
      sign_r_reg   <= sign_r_next;
      div0_reg     <= div0_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      quot_out_reg <= quot_out_next;
      rem_out_reg  <= rem_out_next;
    end
  end

  assign busy      = busy_reg;
  assign done      = done_reg;
  assign quotient  = quot_out_reg;
  assign remainder = rem_out_reg;

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Multi-cycle restoring divider that replaces the single-evaluation combinational unsigned divider in the MIPS execute stage.
- Parametrised operand width; per-operation signed (DIV) or unsigned (DIVU) mode.
- Start/busy/done handshake, plus cancel for pipeline flush on exceptions.
- Drives HI (remainder) and LO (quotient) writeback.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- is_signed  in  1  1 = two's-complement DIV, 0 = DIVU; captured with start.
- dividend  in  WIDTH  captured with start.
- divisor  in  WIDTH  captured with start.
- cancel  in  1  flush; aborts any operation.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; results valid.
- quotient  out  WIDTH  LO result; holds until the next done.
- remainder  out  WIDTH  HI result; holds until the next done.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, quotient=0, remainder=0, counter=0.
- States:
  - IDLE: start=1 and cancel=0 -> CALC. Latch |dividend| and |divisor| (abs only if is_signed), sign_q = sign(a) XOR sign(b), sign_r = sign(a). busy=1 from the next edge.
  - CALC: one restoring step per cycle. Shift {rem,quo} left by 1; if rem_hi >= divisor_abs, subtract and set quo[0]=1. After WIDTH steps -> FIX.
  - FIX: negate quotient if sign_q, negate remainder if sign_r (signed mode only). Register the outputs, done=1, busy=0, -> IDLE.
- Latency: start sampled at edge k -> done high for exactly the cycle following edge k+WIDTH+1 (WIDTH+2 edges inclusive). Throughput: a new start is accepted in the cycle done is high.
- start while busy: ignored, no queuing.
- cancel: any state -> IDLE at the next edge. busy=0, no done, quotient/remainder retain their previous values. cancel with start in IDLE: cancel wins.
- Signed rounding: quotient truncates toward zero; remainder takes the sign of the dividend (MIPS semantics).
- Overflow: MIN / -1 -> quotient=MIN, remainder=0. Wraps naturally; no flag.
- Divide by zero, both modes: quotient = all ones, remainder = dividend as given (sign correction suppressed). Deterministic, no trap.
- Absolute values use WIDTH-bit arithmetic; |MIN| is treated as the unsigned value 2^(WIDTH-1).

Optional Feature:
- Macro: DIV_ITER_FAST_EN.
- Defined:
  - In IDLE, if divisor==0 or |divisor| > |dividend|, skip CALC and go straight to FIX. done arrives 2 edges after start.
  - Results are identical to the full path: zero divisor -> all ones / dividend; |divisor| > |dividend| -> quotient 0, remainder = dividend.
- Undefined: latency is always WIDTH+2 edges and is data-independent.

Decomposition:
- Package div_pkg: state enum (IDLE, CALC, FIX), state-encoding width, localparam for the divide-by-zero quotient pattern.
- Sub-module div_step: combinational single restoring iteration.
  - Inputs: rem, quo, divisor, all WIDTH.
  - Outputs: next rem, next quo.
  - Instantiated once in div_iter.
- FSM, counter and sign handling remain in div_iter.

Test Plan:
- Unsigned, WIDTH=32: 100 / 7 -> quotient 14, remainder 2; done exactly 34 edges after start; busy high throughout.
- Signed: -7 / 2 -> quotient -3 (0xFFFFFFFD), remainder -1. Then 7 / -2 -> -3, 1.
- Overflow, signed: 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
- Divide by zero: 0x1234 / 0, both modes -> quotient 0xFFFFFFFF, remainder 0x1234. With DIV_ITER_FAST_EN, done arrives 2 edges after start.
- cancel asserted at CALC iteration 10 -> no done pulse, busy low next edge, outputs unchanged. start during busy ignored. Back-to-back start in the done cycle is accepted.
- Reset: drop rst_n mid-CALC asynchronously -> busy/done/outputs 0 immediately. Randomized 10k ops vs reference model, WIDTH=8 and 32.
